hpdc_mem_responder: RTL

//  Memory-side responder for the HPDcache memory interface (sargantana_hpdc_pkg types).

---
 rtl/hpdc_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hpdc_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hpdc_mem_responder (+ sargantana_hpdc_pkg)                   |
// | Description : Memory-side responder for the HPDcache memory interface.    |
// |               Serves read bursts and write bursts from an internal array   |
// |               of bus-width words. Independent read and write channels.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package sargantana_hpdc_pkg;
  localparam int unsigned HPDCACHE_MEM_ADDR_WIDTH = 64;
  localparam int unsigned HPDCACHE_MEM_ID_WIDTH   = 8;
  localparam int unsigned HPDCACHE_MEM_DATA_WIDTH = 512;
  localparam int unsigned HPDCACHE_MEM_BE_WIDTH   = HPDCACHE_MEM_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    HPDCACHE_MEM_READ   = 2'b00,
    HPDCACHE_MEM_WRITE  = 2'b01,
    HPDCACHE_MEM_ATOMIC = 2'b10
  } hpdcache_mem_command_e;

  typedef struct packed {
    logic [HPDCACHE_MEM_ADDR_WIDTH-1:0] mem_req_addr;
    logic [7:0]                         mem_req_len;
    logic [2:0]                         mem_req_size;
    logic [HPDCACHE_MEM_ID_WIDTH-1:0]   mem_req_id;
    hpdcache_mem_command_e              mem_req_command;
    logic [3:0]                         mem_req_atomic;
    logic                               mem_req_cacheable;
  } hpdcache_mem_req_t;

  typedef struct packed {
    logic                               mem_resp_r_error;
    logic [HPDCACHE_MEM_ID_WIDTH-1:0]   mem_resp_r_id;
    logic [HPDCACHE_MEM_DATA_WIDTH-1:0] mem_resp_r_data;
    logic                               mem_resp_r_last;
  } hpdcache_mem_resp_r_t;

  typedef struct packed {
    logic [HPDCACHE_MEM_DATA_WIDTH-1:0] mem_req_w_data;
    logic [HPDCACHE_MEM_BE_WIDTH-1:0]   mem_req_w_be;
    logic                               mem_req_w_last;
  } hpdcache_mem_req_w_t;

  typedef struct packed {
    logic                               mem_resp_w_is_atomic;
    logic                               mem_resp_w_error;
    logic [HPDCACHE_MEM_ID_WIDTH-1:0]   mem_resp_w_id;
  } hpdcache_mem_resp_w_t;
endpackage

module hpdc_mem_responder
  import sargantana_hpdc_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  mem_req_read_valid_i,
  output logic                  mem_req_read_ready_o,
  input  hpdcache_mem_req_t     mem_req_read_i,
  output logic                  mem_resp_read_valid_o,
  input  logic                  mem_resp_read_ready_i,
  output hpdcache_mem_resp_r_t  mem_resp_read_o,
  input  logic                  mem_req_write_valid_i,
  output logic                  mem_req_write_ready_o,
  input  hpdcache_mem_req_t     mem_req_write_i,
  input  logic                  mem_req_write_data_valid_i,
  output logic                  mem_req_write_data_ready_o,
  input  hpdcache_mem_req_w_t   mem_req_write_data_i,
  output logic                  mem_resp_write_valid_o,
  input  logic                  mem_resp_write_ready_i,
  output hpdcache_mem_resp_w_t  mem_resp_write_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned DW      = HPDCACHE_MEM_DATA_WIDTH;
  localparam int unsigned BW      = HPDCACHE_MEM_BE_WIDTH;
  localparam int unsigned IW      = HPDCACHE_MEM_ID_WIDTH;
  localparam logic [63:0] C_DEPTH = 64'(DEPTH);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_BURST = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;

  // Storage (not reset)
  logic [DW-1:0] mem_q [DEPTH];

  // Goes high one cycle after reset release; gates all ready outputs
  logic run_q;

  // Read channel state
  rd_state_e     rd_state_q, rd_state_d;
  logic [IW-1:0] rd_id_q;
  logic [63:0]   rd_word_q;
  logic [7:0]    rd_len_q;
  logic          rd_base_err_q;
  logic [7:0]    rd_k_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_err_q;
  logic          rd_last_q;

  // Write channel state
  wr_state_e     wr_state_q, wr_state_d;
  logic [IW-1:0] wr_id_q;
  logic [63:0]   wr_word_q;
  logic [7:0]    wr_len_q;
  logic          wr_base_err_q;
  logic          wr_atomic_q;
  logic          wr_err_q;
  logic [8:0]    wr_k_q;

  // Read-side combinational helpers
  logic [63:0]   w_rd_off;
  logic          w_rd_req_hs;
  logic          w_rd_fetch;
  logic [7:0]    w_rd_fetch_k;
  logic [63:0]   w_rd_idx;
  logic          w_rd_oor;

  // Write-side combinational helpers
  logic [63:0]   w_wr_off;
  logic          w_wr_req_hs;
  logic          w_wr_beat;
  logic [63:0]   w_wr_idx;
  logic          w_wr_oor;
  logic          w_wr_store;
  logic          w_wr_is_atomic;

  assign mem_req_read_ready_o       = run_q && (rd_state_q == R_IDLE);
  assign mem_resp_read_valid_o      = (rd_state_q == R_BURST);
  assign mem_req_write_ready_o      = run_q && (wr_state_q == W_IDLE);
  assign mem_req_write_data_ready_o = run_q && (wr_state_q == W_DATA);
  assign mem_resp_write_valid_o     = (wr_state_q == W_RESP);

  assign w_rd_off     = mem_req_read_i.mem_req_addr - BASE_ADDR;
  assign w_rd_req_hs  = mem_req_read_valid_i && mem_req_read_ready_o;
  // R_FETCH loads beat k; an accepted non-last beat loads k+1 on the same edge
  assign w_rd_fetch_k = (rd_state_q == R_FETCH) ? rd_k_q : rd_k_q + 8'd1;
  assign w_rd_fetch   = (rd_state_q == R_FETCH) ||
                        ((rd_state_q == R_BURST) && mem_resp_read_ready_i && !rd_last_q);
  assign w_rd_idx     = rd_word_q + {56'd0, w_rd_fetch_k};
  assign w_rd_oor     = rd_base_err_q || (w_rd_idx >= C_DEPTH);

  assign w_wr_off       = mem_req_write_i.mem_req_addr - BASE_ADDR;
  assign w_wr_req_hs    = mem_req_write_valid_i && mem_req_write_ready_o;
  assign w_wr_beat      = mem_req_write_data_valid_i && mem_req_write_data_ready_o;
  assign w_wr_idx       = wr_word_q + {55'd0, wr_k_q};
  assign w_wr_oor       = wr_base_err_q || (w_wr_idx >= C_DEPTH);
  assign w_wr_store     = w_wr_beat && !w_wr_oor && !wr_atomic_q;
  assign w_wr_is_atomic = (mem_req_write_i.mem_req_command == HPDCACHE_MEM_ATOMIC);

  logic w_unused_ok;
  assign w_unused_ok = ^{mem_req_read_i.mem_req_size, mem_req_read_i.mem_req_command,
                         mem_req_read_i.mem_req_atomic, mem_req_read_i.mem_req_cacheable,
                         mem_req_write_i.mem_req_size, mem_req_write_i.mem_req_atomic,
                         mem_req_write_i.mem_req_cacheable, w_rd_off[5:0], w_wr_off[5:0]};

  always_comb begin
    mem_resp_read_o                  = '0;
    mem_resp_read_o.mem_resp_r_error = rd_err_q;
    mem_resp_read_o.mem_resp_r_id    = rd_id_q;
    mem_resp_read_o.mem_resp_r_data  = rd_data_q;
    mem_resp_read_o.mem_resp_r_last  = rd_last_q;
  end

  always_comb begin
    mem_resp_write_o                      = '0;
    mem_resp_write_o.mem_resp_w_is_atomic = wr_atomic_q;
    mem_resp_write_o.mem_resp_w_error     = wr_err_q;
    mem_resp_write_o.mem_resp_w_id        = wr_id_q;
  end

  // Run flag: keeps readies low while in reset and for the first cycle after
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  // Read FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rd_state_q <= R_IDLE;
    else         rd_state_q <= rd_state_d;
  end

  // Read FSM next-state logic
  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE:  if (w_rd_req_hs) rd_state_d = R_FETCH;
      R_FETCH: rd_state_d = R_BURST;
      R_BURST: if (mem_resp_read_ready_i && rd_last_q) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read datapath: latch request, then registered array read per beat
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_id_q       <= '0;
      rd_word_q     <= '0;
      rd_len_q      <= '0;
      rd_base_err_q <= 1'b0;
      rd_k_q        <= '0;
      rd_data_q     <= '0;
      rd_err_q      <= 1'b0;
      rd_last_q     <= 1'b0;
    end else begin
      if (w_rd_req_hs) begin
        rd_id_q       <= mem_req_read_i.mem_req_id;
        rd_word_q     <= {6'd0, w_rd_off[63:6]};
        rd_len_q      <= mem_req_read_i.mem_req_len;
        rd_base_err_q <= (mem_req_read_i.mem_req_addr < BASE_ADDR);
        rd_k_q        <= '0;
      end
      if (w_rd_fetch) begin
        rd_k_q    <= w_rd_fetch_k;
        rd_data_q <= w_rd_oor ? '0 : mem_q[w_rd_idx[AW-1:0]];
        rd_err_q  <= w_rd_oor;
        rd_last_q <= (w_rd_fetch_k == rd_len_q);
      end
    end
  end

  // Write FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) wr_state_q <= W_IDLE;
    else         wr_state_q <= wr_state_d;
  end

  // Write FSM next-state logic
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      W_IDLE:  if (w_wr_req_hs) wr_state_d = W_DATA;
      W_DATA:  if (w_wr_beat && mem_req_write_data_i.mem_req_w_last) wr_state_d = W_RESP;
      W_RESP:  if (mem_resp_write_ready_i) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write datapath: latch request, track beat index and accumulate error
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_id_q       <= '0;
      wr_word_q     <= '0;
      wr_len_q      <= '0;
      wr_base_err_q <= 1'b0;
      wr_atomic_q   <= 1'b0;
      wr_err_q      <= 1'b0;
      wr_k_q        <= '0;
    end else begin
      if (w_wr_req_hs) begin
        wr_id_q       <= mem_req_write_i.mem_req_id;
        wr_word_q     <= {6'd0, w_wr_off[63:6]};
        wr_len_q      <= mem_req_write_i.mem_req_len;
        wr_base_err_q <= (mem_req_write_i.mem_req_addr < BASE_ADDR);
        wr_atomic_q   <= w_wr_is_atomic;
        wr_err_q      <= w_wr_is_atomic;
        wr_k_q        <= '0;
      end
      if (w_wr_beat) begin
        if (wr_k_q != '1) wr_k_q <= wr_k_q + 9'd1;
        if (w_wr_oor ||
            (mem_req_write_data_i.mem_req_w_last && (wr_k_q < {1'b0, wr_len_q})) ||
            (!mem_req_write_data_i.mem_req_w_last && (wr_k_q >= {1'b0, wr_len_q})))
          wr_err_q <= 1'b1;
      end
    end
  end

  // Byte-enabled array write at the data-beat handshake edge
  always_ff @(posedge clk_i) begin
    if (w_wr_store) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_req_write_data_i.mem_req_w_be[b])
          mem_q[w_wr_idx[AW-1:0]][b*8 +: 8] <= mem_req_write_data_i.mem_req_w_data[b*8 +: 8];
      end
    end
  end

endmodule
`default_nettype wire
